laplace_window_gen: RTL
=======================

# laplace_window_gen

Raster-to-window stage directly upstream of `laplace9_aprox_4`. It accepts one 8-bit pixel per handshake in raster order, buffers the two previous image rows, and presents the five-point cross window (`b`, `d`, `e`, `f`, `h`) for every interior pixel. For a COLS×ROWS frame it emits (COLS-2)×(ROWS-2) windows, so a 512×512 frame yields 510×510 windows. Outputs connect directly to the filter's `b`, `d`, `e`, `f`, `h` inputs.

## Interface
- `WIDTH`, 8, pixel bit width
- `COLS`, 512, pixels per row (≥3)
- `ROWS`, 512, rows per frame (≥3)
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  `in_pixel` is valid
- `in_ready`  out  1  block accepts a pixel this cycle
- `in_pixel`  in  WIDTH  raster-order pixel
- `out_valid`  out  1  window registers hold a valid window
- `out_ready`  in  1  downstream consumes the window
- `b`, `d`, `e`, `f`, `h`  out  WIDTH each  cross window: north, west, centre, east, south
- `out_last`  out  1  window is the final window of the frame
- `frame_done`  out  1  one-cycle pulse after the final window is consumed

## Operation
- Accept when `in_valid && in_ready`. `in_ready = !out_valid || out_ready` (single skid-free output stage).
- Column counter `C` counts 0..COLS-1. Row counter `R` counts 0..ROWS-1. Both advance only on accept. `C` wraps to 0 and increments `R`. After pixel (ROWS-1, COLS-1), both wrap to 0.
- Line buffers: `lb1` holds row R-1 and `lb0` holds row R-2, each COLS entries.
  - On accept at column C, read `lb1[C]` and `lb0[C]`.
  - Write `lb1[C] <= in_pixel` and `lb0[C] <= old lb1[C]`.
- Three 3-tap shift registers (rows R, R-1, R-2) shift on accept.
- A window is produced on accepting (R, C) with R≥2 and C≥2. It is registered as:
  - `b` = (R-2, C-1)
  - `d` = (R-1, C-2)
  - `e` = (R-1, C-1)
  - `f` = (R-1, C)
  - `h` = (R, C-1)
- Output registers and `out_valid` load only on a producing accept. Otherwise `out_valid` clears when `out_ready`. Windows stay stable while `out_valid && !out_ready`.
- `out_last` is set with the window produced by (ROWS-1, COLS-1).
- FSM:
  - FILL: R<2. No windows produced. Moves to RUN on accepting (1, COLS-1).
  - RUN: windows produced per the rule above. Moves to LAST on accepting (ROWS-1, COLS-1).
  - LAST: `in_ready` = 0 until the last window is consumed. On consume, pulse `frame_done` and move to FILL.
- No arithmetic. Counters are ⌈log2⌉ wide and compared against COLS-1 and ROWS-1.

## Timing
- Latency: 1 cycle from accepting a producing pixel to `out_valid`.
- Throughput: 1 window per cycle with `out_ready` held high.
- Reset values:
  - `out_valid`, `out_last`, `frame_done` = 0.
  - `b`/`d`/`e`/`f`/`h` = 0, shift taps = 0.
  - `R` = `C` = 0, state = FILL.
  - `in_ready` = 1.
  - Line buffer contents are not reset; FILL never emits them.
- Reset asserted mid-frame discards the frame immediately. The next accepted pixel is (0,0).
- Boundaries:
  - Pixels with C<2 or R<2 never assert `out_valid`.
  - The row wrap from C = COLS-1 to 0 produces no window for columns 0–1.
  - A simultaneous consume and producing accept reloads the outputs with no bubble.

## Configuration
- `LAPLACE_WIN_COORD_EN` defined: adds outputs `out_row` and `out_col` (16 bits each). They give the centre coordinate (R-1, C-1) minus 1 in each axis, i.e. the 0-based output index (0..ROWS-3, 0..COLS-3), and are registered with the window.
- Undefined: these ports and their registers do not exist. Behaviour is otherwise identical.

## Structure
- Package `laplace_pkg`:
  - `pixel_t` (logic [WIDTH-1:0])
  - `win_state_t` enum {FILL, RUN, LAST}
  - constants `IMG_COLS` = 512 and `IMG_ROWS` = 512
- Sub-module `line_buffer`: COLS×WIDTH, one write port, combinational read at the same address. Read-during-write returns the old data. Instantiated twice.

## Test plan
- Single 512×512 frame with pixel = (row+col) mod 256, `out_ready` = 1. First window is b=1, d=1, e=2, f=3, h=3. Exactly 260100 windows; `out_last` only on the last one. Output file matches the existing golden indexing of `laplace9_aprox_4` bit-exactly.
- Hold `out_ready` = 0 for 5 cycles mid-row. `in_ready` drops, windows are held stable, no pixel is lost, and the window count is unchanged.
- COLS=8, ROWS=6 with random `in_valid` and `out_ready`: 24 windows, each matching a reference model.
- Assert `rst_n` after 700 pixels. Outputs clear asynchronously, then the next full frame produces correct windows from (0,0).
- Two back-to-back frames: `frame_done` pulses once per frame, and the second frame's first window uses no first-frame data.
- Build with `LAPLACE_WIN_COORD_EN`: the first window reports `out_row`=0, `out_col`=0, and the last reports 509/509.

Source files
------------

// File: rtl/laplace_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : laplace_pkg
//  Description : Shared types and image-size constants for the Laplace
//                window generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package laplace_pkg;

    // Default pixel width and frame geometry of the downstream filter
    localparam int PIXEL_WIDTH = 8;
    localparam int IMG_COLS    = 512;
    localparam int IMG_ROWS    = 512;

    typedef logic [PIXEL_WIDTH-1:0] pixel_t;

    // FILL: first two rows loading; RUN: windows produced; LAST: final window pending
    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1,
        LAST = 2'd2
    } win_state_t;

endpackage : laplace_pkg
`default_nettype wire

// File: rtl/line_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : line_buffer
//  Description : One image row of storage. Single write port, combinational
//                read at the same address; a read in the write cycle returns
//                the previous contents. Storage is intentionally not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 512
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Old-data read: the write only lands at the clock edge
    assign rdata = r_mem[addr];

    // Single write port
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
    end

endmodule : line_buffer
`default_nettype wire

// File: rtl/laplace_window_gen.sv
`default_nettype none
// ============================================================================
//  Module      : laplace_window_gen
//  Description : Raster-to-window stage. Buffers two rows and presents the
//                five-point cross window (b,d,e,f,h) for each interior pixel
//                through a single registered output stage.
//  Options     : LAPLACE_WIN_COORD_EN adds out_row/out_col output indices.
//  Revision    : 1.0 - initial release
// ============================================================================
module laplace_window_gen
    import laplace_pkg::*;
#(
    parameter int WIDTH = PIXEL_WIDTH,
    parameter int COLS  = IMG_COLS,
    parameter int ROWS  = IMG_ROWS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_pixel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] h,
    output logic             out_last,
    output logic             frame_done
`ifdef LAPLACE_WIN_COORD_EN
    ,
    output logic [15:0]      out_row,
    output logic [15:0]      out_col
`endif
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);

    localparam logic [CW-1:0] c_col_last = CW'(COLS - 1);
    localparam logic [CW-1:0] c_col_two  = CW'(2);
    localparam logic [RW-1:0] c_row_last = RW'(ROWS - 1);
    localparam logic [RW-1:0] c_row_one  = RW'(1);

    win_state_t       r_state;
    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;

    logic             w_accept;
    logic             w_produce;
    logic             w_col_end;
    logic             w_row_end;

    logic [WIDTH-1:0] w_lb1_rd;   // row R-1, column C
    logic [WIDTH-1:0] w_lb0_rd;   // row R-2, column C

    // Row taps; the live line-buffer reads and in_pixel act as the newest tap
    logic [WIDTH-1:0] r_top0;     // (R-2, C-1)
    logic [WIDTH-1:0] r_mid0;     // (R-1, C-1)
    logic [WIDTH-1:0] r_mid1;     // (R-1, C-2)
    logic [WIDTH-1:0] r_cur0;     // (R,   C-1)

    // Single output stage: accept whenever the window register is free or draining
    assign in_ready  = (r_state != LAST) && (!out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_col_end = (r_col == c_col_last);
    assign w_row_end = (r_row == c_row_last);
    // RUN implies R>=2; only the column bound remains to be checked
    assign w_produce = w_accept && (r_state == RUN) && (r_col >= c_col_two);

    // lb1 holds the previous row, lb0 the row before it (fed by lb1's old data)
    line_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (COLS)
    ) u_lb1 (
        .clk   (clk),
        .we    (w_accept),
        .addr  (r_col),
        .wdata (in_pixel),
        .rdata (w_lb1_rd)
    );

    line_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (COLS)
    ) u_lb0 (
        .clk   (clk),
        .we    (w_accept),
        .addr  (r_col),
        .wdata (w_lb1_rd),
        .rdata (w_lb0_rd)
    );

    // Frame sequencing: raster counters, FILL/RUN/LAST state and frame_done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= FILL;
            r_col      <= '0;
            r_row      <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (w_accept) begin
                if (w_col_end) begin
                    r_col <= '0;
                    r_row <= w_row_end ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            case (r_state)
                FILL: begin
                    if (w_accept && w_col_end && (r_row == c_row_one)) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_accept && w_col_end && w_row_end) begin
                        r_state <= LAST;
                    end
                end
                LAST: begin
                    if (out_valid && out_ready) begin
                        frame_done <= 1'b1;
                        r_state    <= FILL;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    // Tap shifting and window output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_top0    <= '0;
            r_mid0    <= '0;
            r_mid1    <= '0;
            r_cur0    <= '0;
            b         <= '0;
            d         <= '0;
            e         <= '0;
            f         <= '0;
            h         <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_top0 <= w_lb0_rd;
                r_mid0 <= w_lb1_rd;
                r_mid1 <= r_mid0;
                r_cur0 <= in_pixel;
            end
            if (w_produce) begin
                b         <= r_top0;
                d         <= r_mid1;
                e         <= r_mid0;
                f         <= w_lb1_rd;
                h         <= r_cur0;
                out_valid <= 1'b1;
                out_last  <= w_col_end && w_row_end;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

`ifdef LAPLACE_WIN_COORD_EN
    // 0-based output index of the window, loaded alongside the window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_row <= '0;
            out_col <= '0;
        end else if (w_produce) begin
            out_row <= 16'(r_row) - 16'd2;
            out_col <= 16'(r_col) - 16'd2;
        end
    end
`endif

endmodule : laplace_window_gen
`default_nettype wire
